// File: rtl/glitc_conf_pkg.sv
// Shared types and constants for the GLITC configuration sequencer.
// Holds the per-channel state encoding, WISHBONE register indices and the
// bit offsets of the fields inside the CTRL and ERR registers.
package glitc_conf_pkg;

  // Channel state encoding; software reads these values from the STATE register.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PULSE     = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } conf_state_e;

  // Register index taken from byte address bits [3:2].
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_STATE = 2'd1;
  localparam logic [1:0] REG_ERR   = 2'd2;

  // CTRL write fields.
  localparam int unsigned CTRL_START_LSB = 0;
  localparam int unsigned CTRL_ABORT_LSB = 8;

  // ERR register fields.
  localparam int unsigned ERR_TIMEOUT_LSB = 0;
  localparam int unsigned ERR_CRC_LSB     = 8;
  localparam int unsigned ERR_LOST_LSB    = 16;

  // Width of the per-channel cycle counter.
  localparam int unsigned CNT_W = 24;

  // A channel is busy while it is actively driving or waiting on the FPGA.
  function automatic logic is_busy(input conf_state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/glitc_conf_sequencer_if.sv
// WISHBONE slave bus bundle for the GLITC configuration sequencer.
// Signal names keep the slave-side _i/_o suffixes so they match the bus map.
interface glitc_conf_sequencer_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [4:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/glitc_conf_channel.sv
// One GLITC configuration channel: INIT_B/DONE synchronisers, the
// configuration FSM, a saturating 24-bit cycle counter and the registered
// PROGRAM_B / ready outputs. Error events are one-cycle pulses to the top.
// Optional build macro: GLITC_CONF_TIMEOUT_EN enables WAIT_INIT and LOAD
// watchdogs; without it those states wait indefinitely.
module glitc_conf_channel
  import glitc_conf_pkg::*;
#(
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 32'd1048575,
  parameter int unsigned DONE_TIMEOUT = 32'd16777215
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        init_b_async,
  input  logic        done_async,
  output conf_state_e state,
  output logic        program_b,
  output logic        gready,
  output logic        init_b_sync,
  output logic        done_sync,
  output logic        timeout_evt,
  output logic        crc_evt,
  output logic        lost_evt
);

  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);

`ifdef GLITC_CONF_TIMEOUT_EN
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
`else
  logic unused_timeouts;
  assign unused_timeouts = ^{INIT_TIMEOUT, DONE_TIMEOUT};
`endif

  conf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             program_b_q, program_b_d;
  logic             gready_q, gready_d;
  logic             init_meta_q, init_meta_d, init_sync_q, init_sync_d;
  logic             done_meta_q, done_meta_d, done_sync_q, done_sync_d;
  logic [CNT_W-1:0] cnt_inc;

  // Counter never wraps: it holds at all-ones.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counter, synchroniser and output computation.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_inc;
    timeout_evt = 1'b0;
    crc_evt     = 1'b0;
    lost_evt    = 1'b0;
    init_meta_d = init_b_async;
    init_sync_d = init_meta_q;
    done_meta_d = done_async;
    done_sync_d = done_meta_q;

    unique case (state_q)
      ST_PULSE: begin
        if (cnt_q >= PROG_LAST) begin
          state_d = ST_WAIT_INIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT_INIT: begin
        if (init_sync_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
`ifdef GLITC_CONF_TIMEOUT_EN
        else if (cnt_q >= INIT_LAST) begin
          state_d     = ST_ERROR;
          timeout_evt = 1'b1;
        end
`endif
      end
      ST_LOAD: begin
        // INIT_B dropping during the load is the FPGA flagging a CRC error.
        if (!init_sync_q) begin
          state_d = ST_ERROR;
          crc_evt = 1'b1;
        end else if (done_sync_q) begin
          state_d = ST_DONE;
        end
`ifdef GLITC_CONF_TIMEOUT_EN
        else if (cnt_q >= DONE_LAST) begin
          state_d     = ST_ERROR;
          timeout_evt = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (!done_sync_q) begin
          state_d  = ST_IDLE;
          lost_evt = 1'b1;
        end
      end
      default: ;
    endcase

    // Software commands override the FSM; abort outranks start, and neither
    // leaves an error event behind since the channel is being redirected.
    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      timeout_evt = 1'b0;
      crc_evt     = 1'b0;
      lost_evt    = 1'b0;
    end else if (start) begin
      state_d     = ST_PULSE;
      cnt_d       = '0;
      timeout_evt = 1'b0;
      crc_evt     = 1'b0;
      lost_evt    = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    program_b_d = (state_d != ST_PULSE);
    gready_d    = (state_d == ST_DONE);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      program_b_q <= 1'b1;
      gready_q    <= 1'b0;
      init_meta_q <= 1'b0;
      init_sync_q <= 1'b0;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      program_b_q <= program_b_d;
      gready_q    <= gready_d;
      init_meta_q <= init_meta_d;
      init_sync_q <= init_sync_d;
      done_meta_q <= done_meta_d;
      done_sync_q <= done_sync_d;
    end
  end

  assign state       = state_q;
  assign program_b   = program_b_q;
  assign gready      = gready_q;
  assign init_b_sync = init_sync_q;
  assign done_sync   = done_sync_q;

endmodule

// File: rtl/glitc_conf_sequencer.sv
// GLITC configuration sequencer top: WISHBONE register decode and the
// write-one-to-clear error flags around NCH glitc_conf_channel instances.
// Registers: 0 CTRL/STATUS, 1 STATE (read-only), 2 ERR (W1C), 3 reads 0.
// NCH must lie in 1..8 and PROG_CYCLES must be at least 2.
// Optional build macro: GLITC_CONF_TIMEOUT_EN adds the timeout flags ERR[7:0].
module glitc_conf_sequencer
  import glitc_conf_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 32'd1048575,
  parameter int unsigned DONE_TIMEOUT = 32'd16777215
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  glitc_conf_sequencer_if.slave   wb,
  output logic [NCH-1:0]          gready_o,
  output logic [NCH-1:0]          PROGRAM_B,
  input  logic [NCH-1:0]          INIT_B,
  input  logic [NCH-1:0]          DONE
);

  logic             bus_req;
  logic             wr_en;
  logic [1:0]       reg_sel;
  logic [NCH-1:0]   ch_start, ch_abort;
  logic [NCH-1:0]   ch_init_sync, ch_done_sync;
  logic [NCH-1:0]   ch_timeout_evt, ch_crc_evt, ch_lost_evt;
  conf_state_e      ch_state [NCH];

  logic [NCH-1:0]   crc_err_q, crc_err_d;
  logic [NCH-1:0]   lost_err_q, lost_err_d;
`ifdef GLITC_CONF_TIMEOUT_EN
  logic [NCH-1:0]   tmo_err_q, tmo_err_d;
`endif

  // Zero-wait WISHBONE slave: every strobed cycle is acknowledged at once.
  assign bus_req   = wb.cyc_i & wb.stb_i;
  assign wr_en     = bus_req & wb.we_i;
  assign reg_sel   = wb.adr_i[3:2];
  assign wb.ack_o  = bus_req;
  assign wb.err_o  = 1'b0;
  assign wb.rty_o  = 1'b0;

  // CTRL writes become one-cycle start/abort commands for each channel.
  assign ch_start = (wr_en && reg_sel == REG_CTRL) ? wb.dat_i[CTRL_START_LSB +: NCH] : '0;
  assign ch_abort = (wr_en && reg_sel == REG_CTRL) ? wb.dat_i[CTRL_ABORT_LSB +: NCH] : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    glitc_conf_channel #(
      .PROG_CYCLES  (PROG_CYCLES),
      .INIT_TIMEOUT (INIT_TIMEOUT),
      .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_ch (
      .clk          (clk_i),
      .rst_n        (rst_n_i),
      .start        (ch_start[g]),
      .abort        (ch_abort[g]),
      .init_b_async (INIT_B[g]),
      .done_async   (DONE[g]),
      .state        (ch_state[g]),
      .program_b    (PROGRAM_B[g]),
      .gready       (gready_o[g]),
      .init_b_sync  (ch_init_sync[g]),
      .done_sync    (ch_done_sync[g]),
      .timeout_evt  (ch_timeout_evt[g]),
      .crc_evt      (ch_crc_evt[g]),
      .lost_evt     (ch_lost_evt[g])
    );
  end

  // Error flags: a new event wins over a simultaneous W1C of the same bit.
  always_comb begin
    logic w1c;
    w1c        = wr_en && (reg_sel == REG_ERR);
    crc_err_d  = (crc_err_q  & ~(w1c ? wb.dat_i[ERR_CRC_LSB  +: NCH] : '0)) | ch_crc_evt;
    lost_err_d = (lost_err_q & ~(w1c ? wb.dat_i[ERR_LOST_LSB +: NCH] : '0)) | ch_lost_evt;
`ifdef GLITC_CONF_TIMEOUT_EN
    tmo_err_d  = (tmo_err_q  & ~(w1c ? wb.dat_i[ERR_TIMEOUT_LSB +: NCH] : '0)) | ch_timeout_evt;
`endif
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_err_q  <= '0;
      lost_err_q <= '0;
`ifdef GLITC_CONF_TIMEOUT_EN
      tmo_err_q  <= '0;
`endif
    end else begin
      crc_err_q  <= crc_err_d;
      lost_err_q <= lost_err_d;
`ifdef GLITC_CONF_TIMEOUT_EN
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  // Read mux; fields are padded to eight channels so unused bits read 0.
  always_comb begin
    logic [7:0]  busy_v, init_v, done_v, gready_v, tmo_v, crc_v, lost_v;
    logic [23:0] state_v;
    busy_v   = '0;
    init_v   = '0;
    done_v   = '0;
    gready_v = '0;
    tmo_v    = '0;
    crc_v    = '0;
    lost_v   = '0;
    state_v  = '0;
    for (int i = 0; i < NCH; i++) begin
      busy_v[i]          = is_busy(ch_state[i]);
      state_v[3*i +: 3]  = ch_state[i];
    end
    init_v[NCH-1:0]   = ch_init_sync;
    done_v[NCH-1:0]   = ch_done_sync;
    gready_v[NCH-1:0] = gready_o;
    crc_v[NCH-1:0]    = crc_err_q;
    lost_v[NCH-1:0]   = lost_err_q;
`ifdef GLITC_CONF_TIMEOUT_EN
    tmo_v[NCH-1:0]    = tmo_err_q;
`endif
    unique case (reg_sel)
      REG_CTRL:  wb.dat_o = {gready_v, done_v, init_v, busy_v};
      REG_STATE: wb.dat_o = {8'h00, state_v};
      REG_ERR:   wb.dat_o = {8'h00, lost_v, crc_v, tmo_v};
      default:   wb.dat_o = '0;
    endcase
  end

  // Address bits outside [3:2] and data bits for absent channels are don't-care.
`ifdef GLITC_CONF_TIMEOUT_EN
  logic unused_bus;
  assign unused_bus = ^{wb.adr_i[4], wb.adr_i[1:0], wb.dat_i};
`else
  logic unused_bus;
  assign unused_bus = ^{wb.adr_i[4], wb.adr_i[1:0], wb.dat_i, ch_timeout_evt};
`endif

endmodule
